// File: rtl/fb_writer_pkg.sv
// Shared types and helpers for the image framebuffer writer: FSM states,
// slot origin arithmetic and gray-pixel to framebuffer-word mapping.
package fb_writer_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      FILL = 2'd1,
      DONE = 2'd2
   } state_t;

   function automatic logic [63:0] slot_base(
      input int unsigned slot,
      input int unsigned origin_row,
      input int unsigned origin_col,
      input int unsigned fb_w,
      input int unsigned slot_stride
   );
      logic [63:0] result;
      result = 64'(origin_row) * 64'(fb_w) + 64'(origin_col) + 64'(slot) * 64'(slot_stride);
      return result;
   endfunction

   // expand=1 copies the gray value into the R, G and B fields of the word.
   function automatic logic [63:0] expand_pix(
      input logic [63:0] pix,
      input int unsigned pix_w,
      input logic        expand
   );
      logic [63:0] result;
      result = pix;
      if (expand) begin
         result = pix | (pix << pix_w) | (pix << (2 * pix_w));
      end
      return result;
   endfunction

endpackage

// File: rtl/fb_addr_gen.sv
// Block/line counters and framebuffer address stepping for one upscaled pixel
// block; also tracks the source pixel position within the frame.
module fb_addr_gen #(
   parameter int IMG_W  = 28,
   parameter int IMG_H  = 28,
   parameter int SCALE  = 10,
   parameter int FB_W   = 720,
   parameter int ADDR_W = 19
) (
   input  logic              uart_sampling_clk,
   input  logic              rst,
   input  logic              load,
   input  logic              step,
   input  logic              clear,
   input  logic [ADDR_W-1:0] base,
   output logic [ADDR_W-1:0] addr,
   output logic              block_last,
   output logic              frame_last
);

   localparam int CW  = (IMG_W > 1) ? $clog2(IMG_W) : 1;
   localparam int RW  = (IMG_H > 1) ? $clog2(IMG_H) : 1;
   localparam int SSW = (SCALE > 1) ? $clog2(SCALE) : 1;

   localparam logic [ADDR_W-1:0] LINE_STEP = ADDR_W'(FB_W - (SCALE - 1));
   localparam logic [ADDR_W-1:0] ROW_STEP  = ADDR_W'(SCALE * FB_W);
   localparam logic [ADDR_W-1:0] COL_STEP  = ADDR_W'(SCALE);

   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [CW-1:0]     col_l_q, col_l_d;
   logic [RW-1:0]     row_l_q, row_l_d;
   logic [SSW-1:0]    col_s_q, col_s_d;
   logic [SSW-1:0]    row_s_q, row_s_d;
   logic              line_last;
   logic              last_col;
   logic              last_row;

   always_comb begin
      line_last  = (col_s_q == SSW'(SCALE - 1));
      block_last = line_last && (row_s_q == SSW'(SCALE - 1));
      last_col   = (col_l_q == CW'(IMG_W - 1));
      last_row   = (row_l_q == RW'(IMG_H - 1));
      frame_last = block_last && last_col && last_row;

      addr_d  = addr_q;
      col_l_d = col_l_q;
      row_l_d = row_l_q;
      col_s_d = col_s_q;
      row_s_d = row_s_q;

      if (clear) begin
         col_l_d = '0;
         row_l_d = '0;
         col_s_d = '0;
         row_s_d = '0;
      end else if (load) begin
         addr_d  = base + ADDR_W'(row_l_q) * ROW_STEP + ADDR_W'(col_l_q) * COL_STEP;
         col_s_d = '0;
         row_s_d = '0;
      end else if (step) begin
         if (block_last) begin
            // Block finished: move to the next source pixel, wrapping to 0,0 at frame end.
            col_s_d = '0;
            row_s_d = '0;
            if (last_col) begin
               col_l_d = '0;
               row_l_d = last_row ? '0 : row_l_q + RW'(1);
            end else begin
               col_l_d = col_l_q + CW'(1);
            end
         end else if (line_last) begin
            col_s_d = '0;
            row_s_d = row_s_q + SSW'(1);
            addr_d  = addr_q + LINE_STEP;
         end else begin
            col_s_d = col_s_q + SSW'(1);
            addr_d  = addr_q + ADDR_W'(1);
         end
      end
   end

   always_ff @(posedge uart_sampling_clk or posedge rst) begin
      if (rst) begin
         addr_q  <= '0;
         col_l_q <= '0;
         row_l_q <= '0;
         col_s_q <= '0;
         row_s_q <= '0;
      end else begin
         addr_q  <= addr_d;
         col_l_q <= col_l_d;
         row_l_q <= row_l_d;
         col_s_q <= col_s_d;
         row_s_q <= row_s_d;
      end
   end

   assign addr = addr_q;

endmodule

// File: rtl/image_fb_writer.sv
// Writes a UART-received gray image into the video framebuffer, upscaling each
// pixel to a SCALE x SCALE block inside one of N_SLOTS display slots.
module image_fb_writer
   import fb_writer_pkg::*;
#(
   parameter int IMG_W       = 28,
   parameter int IMG_H       = 28,
   parameter int SCALE       = 10,
   parameter int FB_W        = 720,
   parameter int ORIGIN_ROW  = 100,
   parameter int ORIGIN_COL  = 40,
   parameter int N_SLOTS     = 2,
   parameter int SLOT_STRIDE = 360,
   parameter int PIX_W       = 8,
   parameter int DATA_W      = 32,
   parameter int ADDR_W      = 19,
   parameter int EXPAND      = 1,
   localparam int SLOT_W     = (N_SLOTS > 1) ? $clog2(N_SLOTS) : 1
) (
   input  logic              uart_sampling_clk,
   input  logic              rst,
   input  logic              pix_valid,
   input  logic [PIX_W-1:0]  pix_data,
   output logic              pix_ready,
   input  logic              frame_abort,
   input  logic              auto_advance,
   input  logic [SLOT_W-1:0] slot_sel,
   output logic              fb_we,
   output logic [ADDR_W-1:0] fb_addr,
   output logic [DATA_W-1:0] fb_data,
   output logic              frame_done,
   output logic [SLOT_W-1:0] cur_slot,
   output logic              busy
);

   localparam logic [63:0] MAX_ADDR =
      slot_base(N_SLOTS - 1, ORIGIN_ROW, ORIGIN_COL, FB_W, SLOT_STRIDE)
      + 64'((IMG_H * SCALE - 1) * FB_W) + 64'(IMG_W * SCALE - 1);

   if (MAX_ADDR >= (64'd1 << ADDR_W)) begin : g_addr_overflow
      $error("image_fb_writer: highest framebuffer address does not fit in ADDR_W bits");
   end
   if (SLOT_STRIDE * (N_SLOTS - 1) + IMG_W * SCALE + ORIGIN_COL > FB_W) begin : g_slot_overflow
      $error("image_fb_writer: rightmost slot runs past the framebuffer line");
   end
   if (EXPAND != 0 && DATA_W < 3 * PIX_W) begin : g_data_too_narrow
      $error("image_fb_writer: DATA_W too narrow for RGB replication");
   end

   state_t            state_q, state_d;
   logic              fb_we_q, fb_we_d;
   logic [DATA_W-1:0] fb_data_q, fb_data_d;
   logic              frame_done_q, frame_done_d;
   logic              busy_q, busy_d;
   logic [SLOT_W-1:0] cur_slot_q, cur_slot_d;

   logic              accept;
   logic              slot_sel_ok;
   logic [ADDR_W-1:0] base_addr;
   logic              block_last;
   logic              frame_last;

   // Abort gates ready so a coincident pixel is never taken.
   assign pix_ready   = (state_q == IDLE) && !frame_abort;
   assign accept      = pix_valid && pix_ready;
   assign slot_sel_ok = 32'(slot_sel) < N_SLOTS;
   assign base_addr   = ADDR_W'(slot_base(32'(cur_slot_d), ORIGIN_ROW, ORIGIN_COL, FB_W, SLOT_STRIDE));

   always_comb begin
      state_d      = state_q;
      fb_we_d      = 1'b0;
      fb_data_d    = fb_data_q;
      frame_done_d = 1'b0;
      busy_d       = busy_q;
      cur_slot_d   = cur_slot_q;

      if (frame_abort) begin
         state_d = IDLE;
         busy_d  = 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               if (accept) begin
                  state_d   = FILL;
                  fb_we_d   = 1'b1;
                  fb_data_d = DATA_W'(expand_pix(64'(pix_data), PIX_W, EXPAND != 0));
                  busy_d    = 1'b1;
                  // Slot is only chosen on the first pixel of a frame.
                  if (!busy_q && !auto_advance && slot_sel_ok) begin
                     cur_slot_d = slot_sel;
                  end
               end
            end
            FILL: begin
               if (!block_last) begin
                  fb_we_d = 1'b1;
               end else if (frame_last) begin
                  state_d      = DONE;
                  frame_done_d = 1'b1;
                  busy_d       = 1'b0;
                  if (auto_advance) begin
                     cur_slot_d = (cur_slot_q == SLOT_W'(N_SLOTS - 1)) ? '0 : cur_slot_q + SLOT_W'(1);
                  end
               end else begin
                  state_d = IDLE;
               end
            end
            DONE: begin
               state_d = IDLE;
            end
            default: begin
               state_d = IDLE;
            end
         endcase
      end
   end

   always_ff @(posedge uart_sampling_clk or posedge rst) begin
      if (rst) begin
         state_q      <= IDLE;
         fb_we_q      <= 1'b0;
         fb_data_q    <= '0;
         frame_done_q <= 1'b0;
         busy_q       <= 1'b0;
         cur_slot_q   <= '0;
      end else begin
         state_q      <= state_d;
         fb_we_q      <= fb_we_d;
         fb_data_q    <= fb_data_d;
         frame_done_q <= frame_done_d;
         busy_q       <= busy_d;
         cur_slot_q   <= cur_slot_d;
      end
   end

   fb_addr_gen #(
      .IMG_W  (IMG_W),
      .IMG_H  (IMG_H),
      .SCALE  (SCALE),
      .FB_W   (FB_W),
      .ADDR_W (ADDR_W)
   ) u_addr_gen (
      .uart_sampling_clk (uart_sampling_clk),
      .rst               (rst),
      .load              (accept),
      .step              ((state_q == FILL) && !frame_abort),
      .clear             (frame_abort),
      .base              (base_addr),
      .addr              (fb_addr),
      .block_last        (block_last),
      .frame_last        (frame_last)
   );

   assign fb_we      = fb_we_q;
   assign fb_data    = fb_data_q;
   assign frame_done = frame_done_q;
   assign busy       = busy_q;
   assign cur_slot   = cur_slot_q;

endmodule

// File: tb/tb_image_fb_writer.sv
// Bench: a default-geometry writer for address/data literals and async reset,
// plus a small-geometry EXPAND=0 writer driven through whole frames.
module tb_image_fb_writer;

   // small geometry used for full-frame, slot and abort sequences
   localparam int C_W = 4, C_H = 3, C_S = 3, C_FB = 64, C_OR = 2, C_OC = 5;
   localparam int C_NS = 3, C_STR = 16;
   localparam int C_PIX = C_W * C_H;
   localparam int C_BLK = C_S * C_S;
   localparam int A_BLK = 100;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   logic        a_valid = 1'b0, a_abort = 1'b0, a_auto = 1'b0;
   logic [7:0]  a_data = '0;
   logic [0:0]  a_sel = '0;
   logic        a_ready, a_we, a_done, a_busy;
   logic [18:0] a_addr;
   logic [31:0] a_wdata;
   logic [0:0]  a_slot;

   logic        c_valid = 1'b0, c_abort = 1'b0, c_auto = 1'b0;
   logic [7:0]  c_data = '0;
   logic [1:0]  c_sel = '0;
   logic        c_ready, c_we, c_done, c_busy;
   logic [11:0] c_addr;
   logic [31:0] c_wdata;
   logic [1:0]  c_slot;

   int n_cmp = 0;
   int n_bad = 0;

   image_fb_writer u_dut_a (
      .uart_sampling_clk (clk),      .rst          (rst),
      .pix_valid         (a_valid),  .pix_data     (a_data),
      .pix_ready         (a_ready),  .frame_abort  (a_abort),
      .auto_advance      (a_auto),   .slot_sel     (a_sel),
      .fb_we             (a_we),     .fb_addr      (a_addr),
      .fb_data           (a_wdata),  .frame_done   (a_done),
      .cur_slot          (a_slot),   .busy         (a_busy)
   );

   image_fb_writer #(
      .IMG_W (C_W), .IMG_H (C_H), .SCALE (C_S), .FB_W (C_FB),
      .ORIGIN_ROW (C_OR), .ORIGIN_COL (C_OC), .N_SLOTS (C_NS),
      .SLOT_STRIDE (C_STR), .PIX_W (8), .DATA_W (32), .ADDR_W (12), .EXPAND (0)
   ) u_dut_c (
      .uart_sampling_clk (clk),      .rst          (rst),
      .pix_valid         (c_valid),  .pix_data     (c_data),
      .pix_ready         (c_ready),  .frame_abort  (c_abort),
      .auto_advance      (c_auto),   .slot_sel     (c_sel),
      .fb_we             (c_we),     .fb_addr      (c_addr),
      .fb_data           (c_wdata),  .frame_done   (c_done),
      .cur_slot          (c_slot),   .busy         (c_busy)
   );

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Reference address: slot origin, then source pixel block, then offset inside the block.
   function automatic int exp_addr(input int orow, input int ocol, input int fbw, input int stride,
                                   input int w, input int s, input int slot, input int pidx, input int k);
      int rl, cl, rs, cs;
      rl = pidx / w;
      cl = pidx % w;
      rs = k / s;
      cs = k % s;
      return orow * fbw + ocol + slot * stride + (rl * s + rs) * fbw + cl * s + cs;
   endfunction

   task automatic a_pixel(input logic [7:0] px, input int pidx, input int rst_at);
      a_valid = 1'b1;
      a_data  = px;
      #1;
      chk("a_ready_idle", a_ready, 1);
      tick();
      a_valid = 1'b0;
      a_data  = 8'($urandom);
      for (int k = 0; k < A_BLK; k++) begin
         chk("a_we", a_we, 1);
         chk("a_addr", a_addr, exp_addr(100, 40, 720, 360, 28, 10, 0, pidx, k));
         chk("a_data", a_wdata, {8'h00, px, px, px});
         chk("a_ready_fill", a_ready, 0);
         if (pidx == 0 && k == 0)  chk("a_addr_first", a_addr, 72040);
         if (pidx == 0 && k == 10) chk("a_addr_line2", a_addr, 72760);
         if (pidx == 0 && k == 99) chk("a_addr_last", a_addr, 78529);
         if (k == rst_at) begin
            rst = 1'b1;
            #1;
            chk("a_rst_we", a_we, 0);
            chk("a_rst_addr", a_addr, 0);
            chk("a_rst_data", a_wdata, 0);
            chk("a_rst_busy", a_busy, 0);
            chk("a_rst_done", a_done, 0);
            chk("a_rst_slot", a_slot, 0);
            chk("a_rst_ready", a_ready, 1);
            @(negedge clk);
            rst = 1'b0;
            tick();
            $display("a pixel %0d data %02h: reset after write %0d", pidx, px, k);
            return;
         end
         tick();
      end
      chk("a_we_end", a_we, 0);
      chk("a_ready_back", a_ready, 1);
      chk("a_done_mid", a_done, 0);
      chk("a_busy_mid", a_busy, 1);
      $display("a pixel %0d data %02h: %0d writes", pidx, px, A_BLK);
   endtask

   task automatic c_pixel(input logic [7:0] px, input int slot, input int pidx, input bit last);
      int waited;
      waited  = 0;
      c_valid = 1'b1;
      c_data  = px;
      #1;
      while (c_ready !== 1'b1 && waited < 50) begin
         tick();
         waited++;
      end
      chk("c_accept_wait", c_ready, 1);
      tick();
      c_valid = 1'b0;
      c_data  = 8'($urandom);
      for (int k = 0; k < C_BLK; k++) begin
         chk("c_we", c_we, 1);
         chk("c_addr", c_addr, exp_addr(C_OR, C_OC, C_FB, C_STR, C_W, C_S, slot, pidx, k));
         chk("c_data", c_wdata, {24'h0, px});
         chk("c_ready_fill", c_ready, 0);
         chk("c_busy_fill", c_busy, 1);
         tick();
      end
      chk("c_we_end", c_we, 0);
      if (last) begin
         chk("c_done_pulse", c_done, 1);
         chk("c_ready_done", c_ready, 0);
         chk("c_busy_done", c_busy, 0);
         tick();
         chk("c_done_single", c_done, 0);
         chk("c_ready_after_done", c_ready, 1);
      end else begin
         chk("c_done_mid", c_done, 0);
         chk("c_ready_back", c_ready, 1);
         chk("c_busy_mid", c_busy, 1);
      end
      $display("c pixel %0d slot %0d data %02h last %0d", pidx, slot, px, last);
   endtask

   task automatic c_frame(input bit auto_adv, input logic [1:0] sel, input logic [1:0] sel_mid,
                          input int slot_wr, input int slot_after, input int first_px);
      logic [7:0] px;
      c_auto = auto_adv;
      c_sel  = sel;
      for (int p = 0; p < C_PIX; p++) begin
         px = (p == 0 && first_px >= 0) ? 8'(first_px) : 8'($urandom);
         repeat ($urandom_range(0, 2)) tick();
         c_pixel(px, slot_wr, p, p == C_PIX - 1);
         if (p == 0) c_sel = sel_mid;
      end
      chk("c_slot_after", c_slot, slot_after);
      $display("c frame auto %0d sel %0d slot %0d -> %0d", auto_adv, sel, slot_wr, c_slot);
   endtask

   typedef struct {
      bit         auto_adv;
      logic [1:0] sel;
      logic [1:0] sel_mid;
      int         slot_wr;
      int         slot_after;
   } frame_vec_t;

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout, expected finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      frame_vec_t vecs[7];
      int         model_slot, wr, af;
      bit         au;
      logic [1:0] s;

      vecs[0] = '{1'b1, 2'd2, 2'd0, 0, 1};
      vecs[1] = '{1'b1, 2'd0, 2'd1, 1, 2};
      vecs[2] = '{1'b1, 2'd1, 2'd2, 2, 0};
      vecs[3] = '{1'b0, 2'd1, 2'd2, 1, 1};
      vecs[4] = '{1'b0, 2'd3, 2'd0, 1, 1};
      vecs[5] = '{1'b0, 2'd2, 2'd0, 2, 2};
      vecs[6] = '{1'b1, 2'd0, 2'd1, 2, 0};

      tick();
      tick();
      chk("rst_a_we", a_we, 0);
      chk("rst_a_addr", a_addr, 0);
      chk("rst_a_data", a_wdata, 0);
      chk("rst_a_done", a_done, 0);
      chk("rst_a_busy", a_busy, 0);
      chk("rst_a_slot", a_slot, 0);
      chk("rst_a_ready", a_ready, 1);
      chk("rst_c_we", c_we, 0);
      chk("rst_c_slot", c_slot, 0);
      chk("rst_c_ready", c_ready, 1);
      @(negedge clk);
      rst = 1'b0;
      tick();

      a_pixel(8'h5A, 0, -1);
      a_pixel(8'hC3, 1, -1);
      a_pixel(8'h07, 2, 20);
      a_pixel(8'h11, 0, -1);

      for (int i = 0; i < 7; i++) begin
         c_frame(vecs[i].auto_adv, vecs[i].sel, vecs[i].sel_mid,
                 vecs[i].slot_wr, vecs[i].slot_after, (i == 0) ? 32'h5A : -1);
      end

      // abort on the 5th write of pixel 5, slot 0, auto_advance on
      c_auto = 1'b1;
      for (int p = 0; p < 5; p++) c_pixel(8'($urandom), 0, p, 1'b0);
      c_valid = 1'b1;
      c_data  = 8'($urandom);
      #1;
      chk("c_abort_accept", c_ready, 1);
      tick();
      c_valid = 1'b0;
      for (int k = 0; k < 5; k++) begin
         chk("c_abort_pre_we", c_we, 1);
         chk("c_abort_pre_addr", c_addr, exp_addr(C_OR, C_OC, C_FB, C_STR, C_W, C_S, 0, 5, k));
         if (k < 4) tick();
      end
      c_abort = 1'b1;
      tick();
      c_abort = 1'b0;
      #1;
      chk("c_abort_we", c_we, 0);
      chk("c_abort_done", c_done, 0);
      chk("c_abort_busy", c_busy, 0);
      chk("c_abort_slot", c_slot, 0);
      chk("c_abort_ready", c_ready, 1);
      for (int i = 0; i < 3; i++) begin
         tick();
         chk("c_abort_quiet_we", c_we, 0);
         chk("c_abort_quiet_done", c_done, 0);
      end
      $display("c abort during pixel 5 write 5");
      c_frame(1'b1, 2'd0, 2'd0, 0, 1, -1);

      // abort together with a pixel offer in IDLE
      c_valid = 1'b1;
      c_abort = 1'b1;
      c_data  = 8'hEE;
      #1;
      chk("c_idle_abort_ready", c_ready, 0);
      tick();
      c_valid = 1'b0;
      c_abort = 1'b0;
      chk("c_idle_abort_we", c_we, 0);
      chk("c_idle_abort_busy", c_busy, 0);
      tick();
      chk("c_idle_abort_we2", c_we, 0);
      chk("c_idle_abort_slot", c_slot, 1);
      $display("c abort with pixel offered in idle");

      model_slot = 1;
      for (int f = 0; f < 4; f++) begin
         au = 1'($urandom_range(0, 1));
         s  = 2'($urandom_range(0, 3));
         wr = (!au && int'(s) < C_NS) ? int'(s) : model_slot;
         af = au ? (wr + 1) % C_NS : wr;
         c_frame(au, s, 2'($urandom_range(0, 3)), wr, af, -1);
         model_slot = af;
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
